// File: rtl/seg7_scan_decoder_if.sv
// Bundle of the multiplexed 7-segment inputs and the decoded results.
//   seg/an       : raw segment drive and digit enables (towards decoder)
//   digits       : decoded hex nibbles, digit i at [4i+3:4i]
//   digit_valid  : per-digit "holds a decoded value" flags
//   update/err   : one-cycle pulses on a decoded / undecodable acceptance
//   update_idx   : digit index associated with update or err
interface seg7_scan_decoder_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        update;
  logic [1:0]  update_idx;
  logic        err;

  modport master (
    output seg, an,
    input  digits, digit_valid, update, update_idx, err
  );

  modport slave (
    input  seg, an,
    output digits, digit_valid, update, update_idx, err
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers four hex digits from a scanned, multiplexed 7-segment display.
// A {an,seg} pattern must be sampled STABLE_CYCLES times in a row with a
// one-hot an before it is accepted into digit register i (an[i]=1).
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : seg7_scan_decoder_if.slave (seg/an in; digits, digit_valid,
//          update, update_idx, err out)
// Parameters: STABLE_CYCLES (2..255), ACTIVE_LOW (invert seg/an at input).
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  seg7_scan_decoder_if.slave bus
);

  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  logic [10:0] in_w;
  logic        legal_w;
  logic        accept_w;
  logic [1:0]  sel_w;
  logic [4:0]  dec_w;

  logic [10:0] sample_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        acc_q, acc_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;
  logic [1:0]  idx_q, idx_d;

  // Returns {hit, value}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h7E: decode = 5'h10;  7'h30: decode = 5'h11;
      7'h6D: decode = 5'h12;  7'h79: decode = 5'h13;
      7'h33: decode = 5'h14;  7'h5B: decode = 5'h15;
      7'h5F: decode = 5'h16;  7'h70: decode = 5'h17;
      7'h7F: decode = 5'h18;  7'h7B: decode = 5'h19;
      7'h77: decode = 5'h1A;  7'h1F: decode = 5'h1B;
      7'h4E: decode = 5'h1C;  7'h3D: decode = 5'h1D;
      7'h4F: decode = 5'h1E;  7'h47: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign in_w    = ACTIVE_LOW ? ~{bus.an, bus.seg} : {bus.an, bus.seg};
  assign legal_w = $onehot(in_w[10:7]);
  // A non-zero count implies sample_q holds a legal, stable pattern, so the
  // acceptance acts on sample_q even if the live input has just moved on.
  assign accept_w = (cnt_q == SC) && !acc_q;
  assign dec_w    = decode(sample_q[6:0]);

  always_comb begin
    sel_w = 2'd0;
    unique case (sample_q[10:7])
      4'b0010: sel_w = 2'd1;
      4'b0100: sel_w = 2'd2;
      4'b1000: sel_w = 2'd3;
      default: sel_w = 2'd0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (!legal_w) begin
      cnt_d = '0;
      acc_d = 1'b0;
    end else if (in_w != sample_q) begin
      cnt_d = 8'd1;
      acc_d = 1'b0;
    end else begin
      if (cnt_q < SC) cnt_d = cnt_q + 8'd1;
      if (accept_w)   acc_d = 1'b1;
    end
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    idx_d    = idx_q;
    if (accept_w) begin
      idx_d = sel_w;
      if (sample_q[6:0] == 7'h00) begin
        valid_d[sel_w] = 1'b0;
      end else if (dec_w[4]) begin
        digits_d[{sel_w, 2'b00} +: 4] = dec_w[3:0];
        valid_d[sel_w] = 1'b1;
        upd_d = 1'b1;
      end else begin
        valid_d[sel_w] = 1'b0;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      digits_q <= '0;
      valid_q  <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      sample_q <= in_w;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.update      = upd_q;
  assign bus.err         = err_q;
  assign bus.update_idx  = idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboarded bench: the driver predicts each acceptance from the run
// lengths it produces and queues the expected outcome; a negedge monitor
// compares both an active-high and an active-low instance every cycle.
module tb_seg7_scan_decoder;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] seg_drv = '0;
  logic [3:0] an_drv  = '0;

  seg7_scan_decoder_if b0();
  seg7_scan_decoder_if b1();

  assign b0.seg = seg_drv;
  assign b0.an  = an_drv;
  assign b1.seg = ~seg_drv;
  assign b1.an  = ~an_drv;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0));
  seg7_scan_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    int unsigned cyc;
    bit          upd;
    bit          err;
    logic [1:0]  idx;
    logic [15:0] dig;
    logic [3:0]  val;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0]  TBL [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [15:0] m_dig = '0;
  logic [3:0]  m_val = '0;
  logic [15:0] cur_dig [2] = '{16'h0, 16'h0};
  logic [3:0]  cur_val [2] = '{4'h0, 4'h0};
  logic [3:0]  prev_a = '0;
  logic [6:0]  prev_s = '0;

  task automatic chk(input int d, input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h expected %0h at cycle %0d", d, n, act, exp, cyc);
    end
  endtask

  // Hold {a,s} for L sampling edges starting at the next posedge.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int unsigned L);
    ev_t e;
    int  idx;
    int  hit;
    if ($onehot(a) && L >= S) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (a[i]) idx = i;
      hit = -1;
      for (int v = 0; v < 16; v++) if (TBL[v] == s) hit = v;
      e.cyc = cyc + 1 + S;
      e.idx = 2'(idx);
      e.upd = 1'b0;
      e.err = 1'b0;
      if (s == 7'h00) begin
        m_val[idx] = 1'b0;
      end else if (hit >= 0) begin
        m_dig[idx*4 +: 4] = 4'(hit);
        m_val[idx] = 1'b1;
        e.upd = 1'b1;
      end else begin
        m_val[idx] = 1'b0;
        e.err = 1'b1;
      end
      e.dig = m_dig;
      e.val = m_val;
      q0.push_back(e);
      q1.push_back(e);
    end
    an_drv = a;
    seg_drv = s;
    prev_a = a;
    prev_s = s;
    repeat (L) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mon(input int d, input logic upd, input logic er, input logic [1:0] idx,
                     input logic [15:0] dig, input logic [3:0] val);
    ev_t e;
    bit  due;
    due = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].cyc <= cyc) begin e = q0.pop_front(); due = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].cyc <= cyc) begin e = q1.pop_front(); due = 1'b1; end
    end
    chk(d, "update_and_err", {31'd0, upd & er}, 32'd0);
    if (due) begin
      chk(d, "accept_cycle", cyc, e.cyc);
      chk(d, "update", {31'd0, upd}, {31'd0, e.upd});
      chk(d, "err", {31'd0, er}, {31'd0, e.err});
      if (e.upd || e.err) chk(d, "update_idx", {30'd0, idx}, {30'd0, e.idx});
      cur_dig[d] = e.dig;
      cur_val[d] = e.val;
    end else begin
      chk(d, "update_idle", {31'd0, upd}, 32'd0);
      chk(d, "err_idle", {31'd0, er}, 32'd0);
    end
    chk(d, "digits", {16'd0, dig}, {16'd0, cur_dig[d]});
    chk(d, "digit_valid", {28'd0, val}, {28'd0, cur_val[d]});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, b0.update, b0.err, b0.update_idx, b0.digits, b0.digit_valid);
      mon(1, b1.update, b1.err, b1.update_idx, b1.digits, b1.digit_valid);
    end
  end

  initial begin
    logic [3:0]  a;
    logic [6:0]  s;
    int unsigned r;

    repeat (2) @(negedge clk);
    rst = 1'b0;

    drive(4'b0001, 7'h79, 5);
    drive(4'b0001, 7'h30, 6);
    drive(4'b0010, 7'h6D, 6);
    drive(4'b0100, 7'h79, 6);
    drive(4'b1000, 7'h33, 6);
    drive(4'b0010, 7'h7D, 4);
    drive(4'b0001, 7'h7E, 3);
    drive(4'b0001, 7'h7F, 1);
    drive(4'b0001, 7'h7E, 5);
    drive(4'b0011, 7'h30, 10);
    drive(4'b0100, 7'h00, 4);
    drive(4'b0100, 7'h79, 4);
    drive(4'b0100, 7'h79 ^ 7'h01, 4);
    drive(4'b0100, 7'h79, 4);

    // Abort a run after two samples with an asynchronous reset.
    drive(4'b0100, 7'h5B, 2);
    #2 rst = 1'b1;
    #1;
    chk(0, "rst_digits", {16'd0, b0.digits}, 32'd0);
    chk(0, "rst_valid", {28'd0, b0.digit_valid}, 32'd0);
    chk(0, "rst_pulses", {29'd0, b0.update, b0.err, b0.update_idx != 2'd0}, 32'd0);
    chk(1, "rst_digits", {16'd0, b1.digits}, 32'd0);
    chk(1, "rst_valid", {28'd0, b1.digit_valid}, 32'd0);
    chk(1, "rst_pulses", {29'd0, b1.update, b1.err, b1.update_idx != 2'd0}, 32'd0);
    m_dig = '0;
    m_val = '0;
    cur_dig[0] = '0; cur_dig[1] = '0;
    cur_val[0] = '0; cur_val[1] = '0;
    prev_a = '0;
    prev_s = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(4'b0100, 7'h5B, 6);

    repeat (200) begin
      do begin
        r = $urandom_range(0, 99);
        if (r < 85) a = 4'b0001 << $urandom_range(0, 3);
        else        a = 4'($urandom_range(0, 15));
        r = $urandom_range(0, 99);
        if (r < 55)      s = TBL[$urandom_range(0, 15)];
        else if (r < 70) s = 7'h00;
        else             s = 7'($urandom);
      end while (a == prev_a && s == prev_s);
      drive(a, s, $urandom_range(1, 7));
    end

    drive(4'b0000, 7'h00, S + 4);
    chk(0, "queue_drained", q0.size(), 32'd0);
    chk(1, "queue_drained", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter STABLE_CYCLES, default 4, legal range 2..255: number of consecutive identical samples required before a pattern is accepted.
REQ-003 Parameter ACTIVE_LOW, default 0: when 1, seg and an are inverted immediately at the input, before sampling.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 seg  input  7  segment drive, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g, lit=1 after polarity.
REQ-007 an  input  4  digit enable, one-hot legal, an[i] selects digit i.
REQ-008 digits  output  16  decoded hex values, digit i at bits [4i+3:4i].
REQ-009 digit_valid  output  4  bit i=1 when digit i currently holds a decoded value.
REQ-010 update  output  1  one-cycle pulse when a digit register is written.
REQ-011 update_idx  output  2  index of the digit written; meaningful only when update=1 or err=1.
REQ-012 err  output  1  one-cycle pulse when a stable, non-blank pattern is not in the decode table.

Function
REQ-013 Decode table (seg -> value) SHALL be: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F (hex seg codes).
REQ-014 {an,seg} SHALL be registered into a sample register on every clk edge.
REQ-015 A run counter SHALL increment, saturating at STABLE_CYCLES, when the new sample equals the previous one and an is one-hot.
REQ-016 On any sample change, the run counter SHALL reload to 1 and the accepted flag SHALL clear.
REQ-017 When an is zero or not one-hot, the run counter SHALL be held at 0 and no acceptance SHALL occur.
REQ-018 Acceptance SHALL occur exactly once per run, on the edge where the counter reaches STABLE_CYCLES with the accepted flag clear; acceptance then sets the accepted flag.
REQ-019 Latency: with inputs constant and legal before edges N..N+STABLE_CYCLES-1, outputs SHALL change at edge N+STABLE_CYCLES.
REQ-020 Acceptance of a table pattern SHALL have these effects: digits[i] written; digit_valid[i]=1; update=1; update_idx=i.
REQ-021 Acceptance of seg=00 (blank) SHALL clear digit_valid[i], leave digits[i] unchanged, and assert neither update nor err.
REQ-022 Acceptance of any other pattern SHALL clear digit_valid[i], assert err=1 for one cycle with update_idx=i, and leave digits[i] unchanged.
REQ-023 update and err SHALL never be asserted in the same cycle, and each SHALL be high for exactly one cycle per acceptance.
REQ-024 A pattern sequence A->B->A, each held STABLE_CYCLES, SHALL produce three acceptances, even if the decoded values repeat.
REQ-025 Digits not being accepted SHALL retain their values and valid bits indefinitely.

Reset
REQ-026 While rst=1, the following SHALL be 0 asynchronously: digits, digit_valid, update, update_idx, err, sample register, run counter, accepted flag.
REQ-027 rst asserted mid-run SHALL abort the run; after release, a full STABLE_CYCLES run SHALL be required before any acceptance.

Verification
REQ-028 STABLE_CYCLES=4, an=0001, seg=79 held 4 edges -> at edge 4: digits[3:0]=3, digit_valid=0001, update=1, update_idx=0; update=0 next cycle; no further pulse while the inputs are held.
REQ-029 Round-robin scan: an=0001/0010/0100/1000 with 30/6D/79/33, each held 6 cycles -> digits=16'h4321, digit_valid=1111, four update pulses.
REQ-030 an=0010, seg=7D (not in table) held 4 edges -> err=1 for one cycle with update_idx=1; digit_valid[1]=0; digits[7:4] unchanged.
REQ-031 Glitch: seg=7E for 3 cycles, then 7F for 1 cycle, then 7E -> no acceptance until 7E has been held 4 further edges; a 1-cycle pattern never accepted; an=0011 held 10 cycles -> no output change.
REQ-032 Reset: rst pulsed at edge 2 of a 4-cycle run -> all outputs 0 immediately, no update pulse; acceptance occurs 4 edges after the first post-release sample.
REQ-033 ACTIVE_LOW=1, an=1110, seg=7'b0000001 (inverted 7E) -> digits[3:0]=0, digit_valid[0]=1.
